// File: rtl/frame_tx_sequencer_pkg.sv
// Shared constants and state encoding for the serial frame transmitter.
// A frame is {trailer, data, header}, with bit 0 leaving the line first.
package frame_tx_sequencer_pkg;

  localparam int FRAME_LEN = 17;
  localparam int GAP_LEN   = 2;
  localparam int DATA_W    = 5;

  // Bit i of each constant is transmitted i-th within its field.
  localparam logic [4:0] FRAME_HEADER  = 5'b01111;   // 1,1,1,1,0
  localparam logic [6:0] FRAME_TRAILER = 7'b1111010; // 0,1,0,1,1,1,1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [16:0] build_frame(input logic [DATA_W-1:0] d);
    return {FRAME_TRAILER, d, FRAME_HEADER};
  endfunction

endpackage

// File: rtl/frame_tx_sequencer_piso.sv
// Parallel-load, LSB-out shift register holding the frame in flight.
// Ones are shifted in from the top, so an exhausted register reads as idle line.
module frame_piso #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         q0
);

  logic [W-1:0] frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '1;
    end else if (load) begin
      frame_q <= din;
    end else if (shift) begin
      frame_q <= {1'b1, frame_q[W-1:1]};
    end
  end

  assign q0 = frame_q[0];

endmodule

// File: rtl/frame_tx_sequencer.sv
// Frame sequencer: a rising edge on start launches one 17-bit frame followed
// by an idle-high gap; done pulses on the first idle cycle afterwards.
module frame_tx_sequencer
  import frame_tx_sequencer_pkg::*;
#(
  parameter int FRAME_LEN = frame_tx_sequencer_pkg::FRAME_LEN,
  parameter int GAP_LEN   = frame_tx_sequencer_pkg::GAP_LEN
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output state_e     dbg_state
);

  logic        clk, reset, start;
  logic [4:0]  data;
  assign clk   = io_in[0];
  assign reset = io_in[1];
  assign start = io_in[2];
  assign data  = io_in[7:3];

  state_e      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        done_q, done_d;
  logic        start_q;
  logic        start_edge;
  logic        load, shift;
  logic        frame_bit;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      start_q   <= start;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_SHIFT;
          bit_idx_d = '0;
          load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_idx_q == 5'(FRAME_LEN - 1)) begin
          state_d   = ST_GAP;
          bit_idx_d = '0;
          gap_cnt_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 5'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'(GAP_LEN - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  frame_piso #(.W(FRAME_LEN)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (build_frame(data)),
    .q0    (frame_bit)
  );

  // Outputs come straight from registers; the line only carries frame data in SHIFT.
  assign io_out[0]   = (state_q == ST_SHIFT) ? frame_bit : 1'b1;
  assign io_out[1]   = (state_q != ST_IDLE);
  assign io_out[2]   = done_q;
  assign io_out[7:3] = bit_idx_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Self-checking bench for frame_tx_sequencer: table-driven frames plus
// hand-written sequences for retrigger, data change, reset abort and back-to-back.
module tb_frame_tx_sequencer;
  import frame_tx_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [4:0] data;
  logic [7:0] io_in, io_out;
  state_e     dbg_state;

  assign io_in = {data, start, reset, clk};

  frame_tx_sequencer dut (
    .io_in     (io_in),
    .io_out    (io_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Expected frames in transmit order, first bit at [16].
  localparam logic [16:0] F_10110 = 17'b11110_01101_0101111;
  localparam logic [16:0] F_00000 = 17'b11110_00000_0101111;
  localparam logic [16:0] F_11111 = 17'b11110_11111_0101111;
  localparam logic [16:0] F_01001 = 17'b11110_10010_0101111;
  localparam logic [16:0] F_00011 = 17'b11110_11000_0101111;
  localparam logic [16:0] F_10101 = 17'b11110_10101_0101111;
  localparam logic [7:0]  IDLE_OUT = 8'b00000_0_0_1;

  typedef struct {
    logic [4:0]  data;
    logic [16:0] frame;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];   // {bit_idx, done, busy, tx} per cycle
  int         tests = 0;
  int         failed = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [16:0] f);
    for (int i = 0; i < 17; i++) exp_q.push_back({5'(i), 1'b0, 1'b1, f[16-i]});
    repeat (2) exp_q.push_back({5'd0, 1'b0, 1'b1, 1'b1});
    exp_q.push_back({5'd0, 1'b1, 1'b0, 1'b1});
  endtask

  // Pops one expectation per cycle; optionally drops start, changes data,
  // or raises start again at cycle retrig_at.
  task automatic drain(input string name, input bit hold, input int retrig_at,
                       input logic [4:0] new_data);
    int j = 0;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, j), io_out, e);
      if (j == 0) begin
        if (!hold) start = 1'b0;
        data = new_data;
      end
      if (retrig_at >= 0 && j == retrig_at) start = 1'b1;
      if (retrig_at >= 0 && j == retrig_at + 2) start = 1'b0;
      j++;
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), io_out, IDLE_OUT);
      check($sformatf("%s_state[%0d]", name, i), 8'(dbg_state), 8'(ST_IDLE));
    end
  endtask

  initial begin
    vecs[0] = '{5'b10110, F_10110};
    vecs[1] = '{5'b00000, F_00000};
    vecs[2] = '{5'b11111, F_11111};
    vecs[3] = '{5'b01001, F_01001};
    vecs[4] = '{5'b00011, F_00011};

    reset = 1'b1;
    start = 1'b0;
    data  = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_out", io_out, IDLE_OUT);
    check("reset_state", 8'(dbg_state), 8'(ST_IDLE));
    reset = 1'b0;
    idle_check("post_reset", 3);

    for (int v = 0; v < 5; v++) begin
      data  = vecs[v].data;
      start = 1'b1;
      expect_frame(vecs[v].frame);
      drain($sformatf("vec%0d", v), 1'b0, -1, ~vecs[v].data);
      idle_check($sformatf("vec%0d_idle", v), 2);
    end

    data  = 5'b11111;
    start = 1'b1;
    expect_frame(F_11111);
    drain("hold", 1'b1, -1, 5'b11111);
    idle_check("hold_idle", 22);
    start = 1'b0;
    idle_check("hold_release", 2);

    data  = 5'b10101;
    start = 1'b1;
    expect_frame(F_10101);
    drain("retrig", 1'b0, 8, 5'b10101);
    idle_check("retrig_idle", 22);

    data  = 5'b00000;
    start = 1'b1;
    expect_frame(F_00000);
    drain("datachg", 1'b0, -1, 5'b11111);
    idle_check("datachg_idle", 2);

    data  = 5'b10110;
    start = 1'b1;
    @(negedge clk);
    check("abort_bit0", io_out, {5'd0, 1'b0, 1'b1, 1'b1});
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_bit5", io_out, {5'd5, 1'b0, 1'b1, 1'b0});
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_out", io_out, IDLE_OUT);
    check("abort_state", 8'(dbg_state), 8'(ST_IDLE));
    reset = 1'b0;
    expect_frame(F_10110);
    drain("post_abort", 1'b0, -1, 5'b10110);
    idle_check("post_abort_idle", 2);

    data  = 5'b11111;
    start = 1'b1;
    expect_frame(F_11111);
    drain("b2b_a", 1'b0, 19, 5'b01001);
    expect_frame(F_01001);
    drain("b2b_b", 1'b0, -1, 5'b00000);
    idle_check("b2b_idle", 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/frame_tx_sequencer.md
FRAME_TX_SEQUENCER -- requirements
Module: frame_tx_sequencer

Interface
REQ-001 Parameters: FRAME_LEN, default 17, serial frame length in bits; GAP_LEN, default 2, idle-high cycles after each frame.
REQ-002 io_in[0]  input  1  clk; single clock, all state on rising edge.
REQ-003 io_in[1]  input  1  reset; synchronous, active-high.
REQ-004 io_in[2]  input  1  start; frame request, rising-edge sensitive.
REQ-005 io_in[7:3]  input  5  data d[4:0]; d[i] = io_in[3+i].
REQ-006 io_out[0]  output  1  tx; serial line, idle high.
REQ-007 io_out[1]  output  1  busy; high while a frame or its gap is in progress.
REQ-008 io_out[2]  output  1  done; one-cycle pulse at frame completion.
REQ-009 io_out[7:3]  output  5  bit_idx; index of the bit currently on tx (0..16), 0 when not in SHIFT.

Function
REQ-010 States SHALL be IDLE, SHIFT, GAP; no other encodings reachable.
REQ-011 Start edge SHALL be detected with a registered start_q: edge = start & ~start_q; start_q updates every cycle, in every state.
REQ-012 In IDLE, an edge SHALL load the frame register, clear bit_idx and enter SHIFT at that clock edge.
REQ-013 Frame, transmitted first to last: 1,1,1,1,0,d0,d1,d2,d3,d4,0,1,0,1,1,1,1 (17 bits).
REQ-014 Data SHALL be sampled only on the accepting edge; later changes have no effect on the frame in flight.
REQ-015 In SHIFT, tx = frame bit bit_idx; each clock shifts one bit and increments bit_idx.
REQ-016 After the bit with bit_idx = FRAME_LEN-1, state SHALL go to GAP and hold tx = 1 for exactly GAP_LEN cycles.
REQ-017 Leaving GAP, state SHALL return to IDLE and done SHALL be high for exactly that first IDLE cycle.
REQ-018 Latency: start edge sampled at clock edge k -> bit0 on tx during cycle k..k+1; last bit during cycle k+16; done high during cycle k+19.
REQ-019 busy SHALL be high in SHIFT and GAP, low in IDLE (including the done cycle).
REQ-020 Start edges while busy SHALL be ignored and not queued; start held high SHALL not retrigger.
REQ-021 A start edge coinciding with the done cycle SHALL be accepted (state is IDLE).
REQ-022 tx SHALL be 1 in IDLE and GAP; all outputs derived from registers only, no combinational path from io_in.

Reset
REQ-023 Reset SHALL take priority over all transitions, including mid-frame.
REQ-024 After a reset edge: state IDLE, tx=1, busy=0, done=0, bit_idx=0, start_q=0, frame register all ones.
REQ-025 A frame aborted by reset SHALL produce no done pulse; start high at reset release SHALL count as an edge on the first post-reset cycle.

Structure
REQ-026 Shared package SHALL hold FRAME_LEN, GAP_LEN, the header constant (1,1,1,1,0), the trailer constant (0,1,0,1,1,1,1) and the state enum.
REQ-027 One sub-module, frame_piso (parallel-load shift register, load/shift enables, LSB-out), SHALL hold the frame register; sequencing stays in the top.

Verification
REQ-028 Reset, then start 0->1 with data=5'b10110 -> tx sequence 1,1,1,1,0,0,1,1,0,1,0,1,0,1,1,1,1, then 1,1; done at cycle k+19.
REQ-029 Start held high for 40 cycles, data=5'b11111 -> exactly one frame, one done pulse.
REQ-030 Second start edge at bit_idx=8 -> ignored; frame completes unchanged; no second frame.
REQ-031 Data changed from 5'b00000 to 5'b11111 during SHIFT -> transmitted data bits remain all 0.
REQ-032 Reset asserted at bit_idx=5 -> next cycle tx=1, busy=0, bit_idx=0, no done pulse.
REQ-033 Start edge in done cycle -> new frame bit0 on tx the next cycle; busy low for exactly one cycle between frames.
